// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned MinDiv = 2;
    localparam int unsigned CfgW   = 32;

    typedef struct packed {
        logic [CfgW-1:0] div;
        logic [CfgW-1:0] high;
    } clk_div_cfg_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow period/high time, pending flag and output registers.
// CLK_DIV_DUTY_EN selects a programmable high time; otherwise high time is floor(D/2).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned DEF_DIV = 100000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         cfg_we_i,
    input  clk_div_cfg_t cfg_i,
    output logic         pending_o,
    output logic         clk_o,
    output logic         tick_o
);

    // The period is held as D-1 so that D = 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] DefLast = CNT_W'(DEF_DIV - 1);
    localparam logic [CNT_W-1:0] DefHigh = CNT_W'(DEF_DIV / 2);

    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sh_last_q, sh_last_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cfg_div, new_last, high_nx;
    logic             wrap;
    logic             unused_cfg;

    assign unused_cfg = ^cfg_i;
    assign cfg_div    = cfg_i.div[CNT_W-1:0];
    assign new_last   = (cfg_div < CNT_W'(MinDiv)) ? CNT_W'(MinDiv - 1) : cfg_div - 1'b1;
    assign wrap       = (cnt_q == last_q);

`ifdef CLK_DIV_DUTY_EN
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] cfg_high;

    assign cfg_high = cfg_i.high[CNT_W-1:0];
    assign high_nx  = high_d;

    always_comb begin
        high_d    = high_q;
        sh_high_d = sh_high_q;
        if (en_i) begin
            if (wrap && pending_q) high_d = sh_high_q;
            if (cfg_we_i) sh_high_d = cfg_high;
        end else if (cfg_we_i) begin
            high_d = cfg_high;
        end else if (pending_q) begin
            high_d = sh_high_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            high_q    <= DefHigh;
            sh_high_q <= DefHigh;
        end else begin
            high_q    <= high_d;
            sh_high_q <= sh_high_d;
        end
    end
`else
    // High time follows the period; odd periods spend the extra cycle low.
    assign high_nx = CNT_W'(({1'b0, last_d} + 1'b1) >> 1);
`endif

    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        sh_last_d = sh_last_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        if (en_i) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pending_q) begin
                    last_d    = sh_last_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Accepts only happen with pending clear, so a write on the wrap edge waits a period.
            if (cfg_we_i) begin
                sh_last_d = new_last;
                pending_d = 1'b1;
            end
        end else if (cfg_we_i) begin
            last_d = new_last;
            cnt_d  = new_last;
        end else if (pending_q) begin
            last_d    = sh_last_q;
            cnt_d     = sh_last_q;
            pending_d = 1'b0;
        end else begin
            cnt_d = last_q;
        end
        clk_d = en_i && (cnt_d < high_nx);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q    <= DefLast;
            cnt_q     <= DefLast;
            sh_last_q <= DefLast;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            sh_last_q <= sh_last_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o = pending_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable/divider; decodes config writes to clk_div_chan instances.
// Optional macro CLK_DIV_DUTY_EN enables a programmable high time per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 17,
    parameter int unsigned DEF_DIV  = 100000,
    localparam int unsigned ChW     = ch_idx_w(CHANNELS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] en_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [ChW-1:0]      cfg_ch_i,
    input  logic [CNT_W-1:0]    cfg_div_i,
    input  logic [CNT_W-1:0]    cfg_high_i,
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] tick_o
);

    localparam int unsigned PendW = 2 ** ChW;

    logic [CHANNELS-1:0] pending;
    logic [PendW-1:0]    pend_ext;
    logic                accept;
    clk_div_cfg_t        cfg;

    // Indices past the last channel read as never pending and select no channel.
    assign pend_ext    = PendW'(pending);
    assign cfg_ready_o = !pend_ext[cfg_ch_i];
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign cfg.div     = CfgW'(cfg_div_i);
    assign cfg.high    = CfgW'(cfg_high_i);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[g]),
            .cfg_we_i  (accept && (cfg_ch_i == ChW'(g))),
            .cfg_i     (cfg),
            .pending_o (pending[g]),
            .clk_o     (clk_o[g]),
            .tick_o    (tick_o[g])
        );
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock-enable/divider generator, the parametrised successor to the fixed 1 kHz divider. Each channel divides `clk_i` by a runtime-loadable period and produces a registered divided clock and a one-cycle tick strobe. Period updates are glitch-free and take effect only at period boundaries. The block sits at the top of the timing tree and feeds the display-scan, debounce and counter logic.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 17: counter and period width in bits.
- `DEF_DIV`, 100000: reset period in `clk_i` cycles for every channel (1 kHz from 100 MHz). Must satisfy 2 ≤ DEF_DIV ≤ 2^CNT_W.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  CHANNELS  per-channel run enable.
- `cfg_valid_i`  in  1  configuration write request.
- `cfg_ready_o`  out  1  configuration write may be accepted; equals `!pending[cfg_ch_i]`.
- `cfg_ch_i`  in  $clog2(CHANNELS) (min 1)  target channel.
- `cfg_div_i`  in  CNT_W  new period D in cycles.
- `cfg_high_i`  in  CNT_W  new high time H in cycles (used only with `CLK_DIV_DUTY_EN`).
- `clk_o`  out  CHANNELS  divided clock, registered.
- `tick_o`  out  CHANNELS  one-cycle pulse at each period start, registered.

## Operation
- Per-channel state: active period D, active high time H, counter `cnt`, shadow D/H, and a `pending` flag.
- Reset values: D=DEF_DIV, H=DEF_DIV/2 (floor), cnt=DEF_DIV-1, pending=0, `clk_o`=0, `tick_o`=0.
- Enabled channel, each edge:
  - cnt==D-1: cnt←0, `tick_o`←1.
  - Otherwise: cnt←cnt+1, `tick_o`←0.
  - `clk_o`←(next cnt < H).
- Disabled channel: cnt←D-1, `clk_o`←0, `tick_o`←0. The first edge with en sampled high therefore wraps: tick and `clk_o` both rise together.
- Config accept = `cfg_valid_i && cfg_ready_o`, sampled at the edge.
  - Target channel enabled: shadow←inputs and pending←1.
  - Target channel disabled: D/H are loaded directly, cnt←newD-1, and pending stays 0.
- Pending apply: at the wrap edge (cnt==D-1) of an enabled channel, D/H←shadow, pending←0, and the new period starts counting with the new values. `clk_o` at that edge already uses the new H.
- Accept and wrap on the same edge: the write goes to the shadow and applies at the following wrap, never the current one.
- A channel disabled while pending=1 applies the pending shadow on the next edge.
- Clamping at load:
  - D<2 is loaded as 2.
  - H≥D gives `clk_o` constant high while enabled.
  - H=0 gives `clk_o` constant low.
  - Tick is unaffected by H.

## Timing
- Latency: en high at edge k gives the first tick at edge k.
- Output period is exactly D cycles. High time is H cycles, low time is D-H cycles.
- `cfg_ready_o` is combinational from `pending` and `cfg_ch_i`. It drops the cycle after an accept to an enabled channel and returns the cycle after the apply wrap.
- Asynchronous reset mid-operation clears all state, including pending writes, immediately.

## Configuration
- Macro `CLK_DIV_DUTY_EN`.
  - Defined: H is taken from `cfg_high_i`, with the clamping rules above.
  - Undefined: `cfg_high_i` is ignored and H=floor(D/2). Odd D is low for the extra cycle. The H shadow registers are not synthesised.

## Structure
- `clk_div_pkg`:
  - Typedef `clk_div_cfg_t` {div, high}.
  - Constants: minimum D (2) and the channel-index width function.
- Sub-module `clk_div_chan`: one channel's counter, shadow, pending and output registers. The top level generates CHANNELS instances and decodes `cfg_ch_i`.

## Test plan
- Reset: hold `rst_i`=0 mid-run → all `clk_o`/`tick_o`=0 and `cfg_ready_o`=1. After release with en=1, ch0 ticks every 100000 cycles and `clk_o` is high for 50000 cycles.
- Waveform: load ch1 D=4, H=2 while disabled, then enable → tick at cycles 0, 4, 8 and `clk_o` pattern 1100 repeating. Without `CLK_DIV_DUTY_EN`, D=5 gives pattern 11000.
- Reconfig mid-period: ch1 running D=4; at cnt=1 write D=6, H=3 → ready low, the current period completes in 4 cycles, then 6-cycle periods 111000. Ready returns the cycle after the wrap.
- Same-edge accept/wrap: write on the wrap edge → the old D holds for one more full period before the change.
- Clamping: write D=0, then D=1 → period 2. H=7 with D=4 gives `clk_o` constant 1 with ticks every 4 cycles. H=0 gives constant 0.
- Multi-channel: while ch2 is pending, write ch3 → ch3 is accepted (`cfg_ready_o`=1 for ch3), and a second write to ch2 is stalled until the ch2 wrap.
